// File: rtl/argmax_pkg.sv
// Shared types and helpers for the argmax classifier stage.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
// Contents: state_e FSM encoding, width/scan-count helpers, score compare.
package argmax_pkg;

  // Widest score the compare helper accepts; scores are zero-extended into it.
  localparam int MAX_SCORE_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  // Class index width: max(1, clog2(num_classes)).
  function automatic int calc_idx_w(input int num_classes);
    return (num_classes <= 2) ? 1 : $clog2(num_classes);
  endfunction

  // Number of scan cycles: ceil(num_classes / lanes).
  function automatic int calc_scan(input int num_classes, input int lanes);
    return (num_classes + lanes - 1) / lanes;
  endfunction

  // Chunk counter width: max(1, clog2(scan_cycles)).
  function automatic int calc_cw(input int scan_cycles);
    return (scan_cycles <= 2) ? 1 : $clog2(scan_cycles);
  endfunction

  // Strict a > b on w-bit scores held zero-extended in the low bits.
  // Flipping the sign bit maps two's-complement order onto unsigned order,
  // so one unsigned comparator serves both modes.
  function automatic logic score_gt(input logic [MAX_SCORE_W-1:0] a,
                                    input logic [MAX_SCORE_W-1:0] b,
                                    input logic                   sgn,
                                    input int                     w);
    logic [MAX_SCORE_W-1:0] flip;
    flip = sgn ? (MAX_SCORE_W'(1) << (w - 1)) : '0;
    return (a ^ flip) > (b ^ flip);
  endfunction

endpackage

// File: rtl/argmax_lane_tree.sv
// Combinational reduction of one chunk of LANES scores to (value, position).
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the parent FSM decides when the result is used.
// Ports: lane_scores_i (LANES packed scores, lane l at [l*BIT_SIZE +: BIT_SIZE]),
//        lane_mask_i (1 = lane holds a real class), base_pos_i (position of lane 0),
//        win_val_o / win_pos_o (best unmasked lane, lowest position on ties).
module argmax_lane_tree
  import argmax_pkg::*;
#(
  parameter int BIT_SIZE = 8,
  parameter int LANES    = 1,
  parameter int IDX_W    = 4,
  parameter int SIGNED   = 0
) (
  input  logic [LANES*BIT_SIZE-1:0] lane_scores_i,
  input  logic [LANES-1:0]          lane_mask_i,
  input  logic [IDX_W-1:0]          base_pos_i,
  output logic [BIT_SIZE-1:0]       win_val_o,
  output logic [IDX_W-1:0]          win_pos_o
);

  localparam logic SGN = (SIGNED != 0);

  always_comb begin
    logic [BIT_SIZE-1:0] best_v;
    logic [IDX_W-1:0]    best_p;
    logic [BIT_SIZE-1:0] cur_v;
    logic                found;
    best_v = BIT_SIZE'(lane_scores_i);
    best_p = base_pos_i;
    cur_v  = '0;
    found  = 1'b0;
    // Lanes are walked in ascending position; only a strictly greater score
    // replaces the current best, which gives lowest-position-wins on ties.
    for (int l = 0; l < LANES; l++) begin
      cur_v = BIT_SIZE'(lane_scores_i >> (l * BIT_SIZE));
      if (lane_mask_i[l] &&
          (!found || score_gt(MAX_SCORE_W'(cur_v), MAX_SCORE_W'(best_v), SGN, BIT_SIZE))) begin
        best_v = cur_v;
        best_p = base_pos_i + IDX_W'(l);
        found  = 1'b1;
      end
    end
    win_val_o = best_v;
    win_pos_o = best_p;
  end

endmodule

// File: rtl/argmax_layer.sv
// Finds index and value of the largest of NUM_CLASSES scores, LANES per cycle.
// Latency: out_valid rises S+1 cycles after the accept cycle (S = scan cycles).
// Backpressure: result held in DONE until out_ready; a new vector can be taken
//   in the same cycle the result is consumed, so there is no bubble.
// Ports: clk/rst (async active-high), in_scores/in_valid/in_ready (input vector,
//        position p at [p*BIT_SIZE +: BIT_SIZE]), out_class/out_max/out_valid/out_ready.
module argmax_layer
  import argmax_pkg::*;
#(
  parameter  int BIT_SIZE      = 8,
  parameter  int NUM_CLASSES   = 10,
  parameter  int LANES         = 1,
  parameter  int SIGNED        = 0,
  parameter  int REVERSE_ORDER = 1,
  localparam int IDX_W         = calc_idx_w(NUM_CLASSES)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [BIT_SIZE*NUM_CLASSES-1:0] in_scores,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [IDX_W-1:0]              out_class,
  output logic [BIT_SIZE-1:0]           out_max,
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam int   S      = calc_scan(NUM_CLASSES, LANES);
  localparam int   CW     = calc_cw(S);
  localparam int   LANE_W = LANES * BIT_SIZE;
  localparam int   PAD_W  = S * LANE_W;
  localparam logic SGN    = (SIGNED != 0);

  state_e                         state_q;
  logic [BIT_SIZE*NUM_CLASSES-1:0] scores_q;
  logic [CW-1:0]                  chunk_q;
  logic [BIT_SIZE-1:0]            best_val_q, best_val_d;
  logic [IDX_W-1:0]               best_pos_q, best_pos_d;
  logic [IDX_W-1:0]               class_d;
  logic                           out_valid_q;
  logic [IDX_W-1:0]               out_class_q;
  logic [BIT_SIZE-1:0]            out_max_q;

  logic [PAD_W-1:0]  padded;
  logic [LANE_W-1:0] lane_scores;
  logic [LANES-1:0]  lane_mask;
  logic [IDX_W-1:0]  base_pos;
  logic [BIT_SIZE-1:0] tree_val;
  logic [IDX_W-1:0]  tree_pos;
  logic              last_chunk;

  // The buffer is zero-padded to a whole number of chunks; the padding
  // lanes are masked off so their contents never matter.
  assign padded      = PAD_W'(scores_q);
  assign lane_scores = LANE_W'(padded >> (int'(chunk_q) * LANE_W));
  assign base_pos    = IDX_W'(int'(chunk_q) * LANES);
  assign last_chunk  = (chunk_q == CW'(S - 1));

  always_comb begin
    lane_mask = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_mask[l] = ((int'(chunk_q) * LANES + l) < NUM_CLASSES);
    end
  end

  argmax_lane_tree #(
    .BIT_SIZE (BIT_SIZE),
    .LANES    (LANES),
    .IDX_W    (IDX_W),
    .SIGNED   (SIGNED)
  ) u_tree (
    .lane_scores_i (lane_scores),
    .lane_mask_i   (lane_mask),
    .base_pos_i    (base_pos),
    .win_val_o     (tree_val),
    .win_pos_o     (tree_pos)
  );

  // Chunk 0 seeds the running best from the data rather than from zero, so
  // all-negative and all-zero vectors resolve correctly. Later chunks only
  // win when strictly greater, keeping the earlier (lower) position on ties.
  always_comb begin
    best_val_d = best_val_q;
    best_pos_d = best_pos_q;
    if (chunk_q == '0 ||
        score_gt(MAX_SCORE_W'(tree_val), MAX_SCORE_W'(best_val_q), SGN, BIT_SIZE)) begin
      best_val_d = tree_val;
      best_pos_d = tree_pos;
    end
    class_d = (REVERSE_ORDER != 0) ? (IDX_W'(NUM_CLASSES - 1) - best_pos_d) : best_pos_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      scores_q    <= '0;
      chunk_q     <= '0;
      best_val_q  <= '0;
      best_pos_q  <= '0;
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      out_max_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            scores_q <= in_scores;
            chunk_q  <= '0;
            state_q  <= SCAN;
          end
        end
        SCAN: begin
          best_val_q <= best_val_d;
          best_pos_q <= best_pos_d;
          if (last_chunk) begin
            out_max_q   <= best_val_d;
            out_class_q <= class_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            chunk_q <= chunk_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (in_valid) begin
              scores_q <= in_scores;
              chunk_q  <= '0;
              state_q  <= SCAN;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Ready in DONE depends on out_ready in the same cycle, which is what
  // lets a consumed result and a new vector share one cycle.
  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_valid = out_valid_q;
  assign out_class = out_class_q;
  assign out_max   = out_max_q;

endmodule
